// File: rtl/ri5cy_ahb_bridge_pipe.sv
// Core-side req/gnt/rvalid bus to AHB-Lite single-transfer master bridge.
// The address phase is combinational and the data phase is tracked by a small FSM.
module ri5cy_ahb_bridge_pipe #(
    parameter int unsigned                AHB_ADDR_WIDTH = 32,
    parameter int unsigned                AHB_DATA_WIDTH = 32,
    parameter logic [AHB_ADDR_WIDTH-1:0]  ADDR_BASE      = '0,
    parameter logic [AHB_ADDR_WIDTH-1:0]  ADDR_SIZE      = AHB_ADDR_WIDTH'(32'h2000_0000),
    parameter logic [3:0]                 HPROT_VAL      = 4'b0011
) (
    input  logic                          core_clk,
    input  logic                          core_rst,
    input  logic                          req_i,
    input  logic                          we_i,
    input  logic [AHB_DATA_WIDTH/8-1:0]   be_i,
    input  logic [AHB_ADDR_WIDTH-1:0]     addr_i,
    input  logic [AHB_DATA_WIDTH-1:0]     wdata_i,
    output logic                          gnt_o,
    output logic                          rvalid_o,
    output logic [AHB_DATA_WIDTH-1:0]     rdata_o,
    output logic                          err_o,
    output logic                          hsel_o,
    output logic [AHB_ADDR_WIDTH-1:0]     haddr_o,
    output logic [AHB_DATA_WIDTH-1:0]     hwdata_o,
    output logic                          hwrite_o,
    output logic [2:0]                    hsize_o,
    output logic [2:0]                    hburst_o,
    output logic [3:0]                    hprot_o,
    output logic [1:0]                    htrans_o,
    output logic                          hmastlock_o,
    output logic                          hready_o,
    input  logic [AHB_DATA_WIDTH-1:0]     hrdata_i,
    input  logic                          hreadyout_i,
    input  logic                          hresp_i,
    output logic [15:0]                   err_cnt_o
);

    localparam int unsigned DB  = AHB_DATA_WIDTH / 8;
    localparam int unsigned DBW = $clog2(DB);

    typedef enum logic [1:0] {
        DP_IDLE,
        DP_BUS,
        DP_OOR,
        DP_ERR
    } dp_state_e;

    dp_state_e                   state_q, state_d;
    logic                        we_q, we_d;
    logic [AHB_DATA_WIDTH-1:0]   hwdata_q, hwdata_d;
    logic [15:0]                 err_cnt_q, err_cnt_d;

    logic [AHB_ADDR_WIDTH-1:0]   addr_off;
    logic                        in_range;
    logic                        accept;
    logic [DBW-1:0]              lo_idx;
    logic [DBW-1:0]              addr_lo;
    logic [2:0]                  size;
    logic                        rvalid;
    logic                        err;
    logic [AHB_DATA_WIDTH-1:0]   rdata;
    logic                        phase_done;

    assign addr_off = addr_i - ADDR_BASE;
    assign in_range = (addr_off < ADDR_SIZE);
    // Reset masks the handshake so nothing is granted or issued while held.
    assign accept   = req_i & hreadyout_i & ~core_rst;

    assign gnt_o       = accept;
    assign hsel_o      = accept & in_range;
    assign htrans_o    = (accept & in_range) ? 2'b10 : 2'b00;
    assign hwrite_o    = we_i;
    assign hsize_o     = size;
    assign haddr_o     = {addr_i[AHB_ADDR_WIDTH-1:DBW], addr_lo};
    assign hwdata_o    = hwdata_q;
    assign hburst_o    = 3'b000;
    assign hmastlock_o = 1'b0;
    assign hprot_o     = HPROT_VAL;
    assign hready_o    = hreadyout_i;
    assign err_cnt_o   = err_cnt_q;
    assign rvalid_o    = rvalid;
    assign err_o       = err;
    assign rdata_o     = rdata;

    // Unrecognised byte-enable patterns fall back to a full-width aligned access.
    always_comb begin
        lo_idx  = '0;
        size    = 3'(DBW);
        addr_lo = '0;
        for (int i = DB - 1; i >= 0; i--) begin
            if (be_i[i]) lo_idx = DBW'(i);
        end
        if ($countones(be_i) == 1) begin
            size    = 3'd0;
            addr_lo = lo_idx;
        end
        for (int k = 0; k < DB / 2; k++) begin
            if (be_i == (DB'(2'b11) << (2 * k))) begin
                size    = 3'd1;
                addr_lo = lo_idx;
            end
        end
        for (int k = 0; k < DB / 4; k++) begin
            if (be_i == (DB'(4'hF) << (4 * k))) begin
                size    = 3'd2;
                addr_lo = lo_idx;
            end
        end
        if (DB == 8 && (&be_i)) begin
            size    = 3'd3;
            addr_lo = '0;
        end
    end

    always_comb begin
        state_d    = state_q;
        rvalid     = 1'b0;
        err        = 1'b0;
        rdata      = '0;
        phase_done = 1'b0;
        case (state_q)
            DP_IDLE: phase_done = 1'b1;
            DP_BUS: begin
                if (hreadyout_i) begin
                    rvalid     = 1'b1;
                    err        = hresp_i;
                    rdata      = (hresp_i || we_q) ? '0 : hrdata_i;
                    phase_done = 1'b1;
                end else if (hresp_i) begin
                    state_d = DP_ERR;
                end
            end
            DP_ERR: begin
                if (hreadyout_i) begin
                    rvalid     = 1'b1;
                    err        = 1'b1;
                    phase_done = 1'b1;
                end
            end
            DP_OOR: begin
                rvalid     = 1'b1;
                err        = 1'b1;
                phase_done = 1'b1;
            end
            default: state_d = DP_IDLE;
        endcase
        if (accept) begin
            state_d = in_range ? DP_BUS : DP_OOR;
        end else if (phase_done) begin
            state_d = DP_IDLE;
        end
        if (core_rst) begin
            rvalid = 1'b0;
            err    = 1'b0;
            rdata  = '0;
        end
    end

    always_comb begin
        we_d      = accept ? we_i : we_q;
        hwdata_d  = (accept && we_i) ? wdata_i : hwdata_q;
        err_cnt_d = err_cnt_q;
        if (rvalid && err && (err_cnt_q != 16'hFFFF)) begin
            err_cnt_d = err_cnt_q + 16'd1;
        end
    end

    always_ff @(posedge core_clk) begin
        if (core_rst) begin
            state_q   <= DP_IDLE;
            we_q      <= 1'b0;
            hwdata_q  <= '0;
            err_cnt_q <= '0;
        end else begin
            state_q   <= state_d;
            we_q      <= we_d;
            hwdata_q  <= hwdata_d;
            err_cnt_q <= err_cnt_d;
        end
    end

endmodule

// File: tb/tb_ri5cy_ahb_bridge_pipe.sv
// Bench for ri5cy_ahb_bridge_pipe: vector table plus hand-written multi-cycle sequences,
// with responses checked against a scoreboard queue filled as requests are granted.
module tb_ri5cy_ahb_bridge_pipe;

    logic        core_clk = 1'b0;
    logic        core_rst;
    logic        req_i, we_i;
    logic [3:0]  be_i;
    logic [31:0] addr_i, wdata_i;
    logic        gnt_o, rvalid_o, err_o;
    logic [31:0] rdata_o;
    logic        hsel_o, hwrite_o, hmastlock_o, hready_o;
    logic [31:0] haddr_o, hwdata_o;
    logic [2:0]  hsize_o, hburst_o;
    logic [3:0]  hprot_o;
    logic [1:0]  htrans_o;
    logic [31:0] hrdata_i;
    logic        hreadyout_i, hresp_i;
    logic [15:0] err_cnt_o;

    always #5 core_clk = ~core_clk;

    ri5cy_ahb_bridge_pipe dut (
        .core_clk   (core_clk),
        .core_rst   (core_rst),
        .req_i      (req_i),
        .we_i       (we_i),
        .be_i       (be_i),
        .addr_i     (addr_i),
        .wdata_i    (wdata_i),
        .gnt_o      (gnt_o),
        .rvalid_o   (rvalid_o),
        .rdata_o    (rdata_o),
        .err_o      (err_o),
        .hsel_o     (hsel_o),
        .haddr_o    (haddr_o),
        .hwdata_o   (hwdata_o),
        .hwrite_o   (hwrite_o),
        .hsize_o    (hsize_o),
        .hburst_o   (hburst_o),
        .hprot_o    (hprot_o),
        .htrans_o   (htrans_o),
        .hmastlock_o(hmastlock_o),
        .hready_o   (hready_o),
        .hrdata_i   (hrdata_i),
        .hreadyout_i(hreadyout_i),
        .hresp_i    (hresp_i),
        .err_cnt_o  (err_cnt_o)
    );

    typedef struct {
        logic        we;
        logic [3:0]  be;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] hrdata;
        logic        exp_sel;
        logic [31:0] exp_haddr;
        logic [2:0]  exp_hsize;
        logic        exp_err;
        logic [31:0] exp_rdata;
    } vec_t;

    typedef struct packed {
        logic        err;
        logic [31:0] rdata;
    } resp_t;

    localparam int NV = 10;
    vec_t  v[NV];
    resp_t sb[$];
    resp_t mon_e;
    int    errors = 0;
    int    checks = 0;
    bit    mon_en = 1'b1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic drive(input logic req, input logic we, input logic [3:0] be,
                         input logic [31:0] addr, input logic [31:0] wdata,
                         input logic hrdy, input logic hresp, input logic [31:0] hrdata);
        @(posedge core_clk);
        #1;
        req_i       = req;
        we_i        = we;
        be_i        = be;
        addr_i      = addr;
        wdata_i     = wdata;
        hreadyout_i = hrdy;
        hresp_i     = hresp;
        hrdata_i    = hrdata;
    endtask

    task automatic do_reset();
        @(posedge core_clk);
        #1;
        core_rst    = 1'b1;
        req_i       = 1'b0;
        hreadyout_i = 1'b1;
        hresp_i     = 1'b0;
        @(posedge core_clk);
        #1;
        core_rst = 1'b0;
    endtask

    always @(negedge core_clk) begin
        if (mon_en && rvalid_o === 1'b1) begin
            if (sb.size() == 0) begin
                chk("rvalid_unexpected", 64'd1, 64'd0);
            end else begin
                mon_e = sb.pop_front();
                chk("resp_err", {63'd0, err_o}, {63'd0, mon_e.err});
                chk("resp_rdata", {32'd0, rdata_o}, {32'd0, mon_e.rdata});
            end
        end
    end

    initial begin
        logic [31:0] prev_hr;
        //        we  be      addr            wdata          hrdata         sel haddr          hsz   err rdata
        v[0] = '{1'b0, 4'hF, 32'h0000_0100, 32'h0,         32'hDEAD_BEEF, 1'b1, 32'h0000_0100, 3'd2, 1'b0, 32'hDEAD_BEEF};
        v[1] = '{1'b1, 4'h8, 32'h0000_0203, 32'h1122_3344, 32'hFFFF_FFFF, 1'b1, 32'h0000_0203, 3'd0, 1'b0, 32'h0};
        v[2] = '{1'b0, 4'hC, 32'h0000_1002, 32'h0,         32'hCAFE_F00D, 1'b1, 32'h0000_1002, 3'd1, 1'b0, 32'hCAFE_F00D};
        v[3] = '{1'b1, 4'h3, 32'h0000_1003, 32'h0BAD_CAFE, 32'hFFFF_FFFF, 1'b1, 32'h0000_1000, 3'd1, 1'b0, 32'h0};
        v[4] = '{1'b0, 4'h6, 32'h0000_2001, 32'h0,         32'h1234_5678, 1'b1, 32'h0000_2000, 3'd2, 1'b0, 32'h1234_5678};
        v[5] = '{1'b0, 4'hF, 32'h3000_0000, 32'h0,         32'hFFFF_FFFF, 1'b0, 32'h3000_0000, 3'd2, 1'b1, 32'h0};
        v[6] = '{1'b1, 4'hF, 32'h1FFF_FFFC, 32'hA5A5_A5A5, 32'hFFFF_FFFF, 1'b1, 32'h1FFF_FFFC, 3'd2, 1'b0, 32'h0};
        v[7] = '{1'b0, 4'h1, 32'h2000_0000, 32'h0,         32'hFFFF_FFFF, 1'b0, 32'h2000_0000, 3'd0, 1'b1, 32'h0};
        v[8] = '{1'b0, 4'h4, 32'h0000_0044, 32'h0,         32'h0BAD_F00D, 1'b1, 32'h0000_0046, 3'd0, 1'b0, 32'h0BAD_F00D};
        v[9] = '{1'b0, 4'h0, 32'h0000_0051, 32'h0,         32'h55AA_55AA, 1'b1, 32'h0000_0050, 3'd2, 1'b0, 32'h55AA_55AA};

        core_rst    = 1'b1;
        req_i       = 1'b1;
        we_i        = 1'b0;
        be_i        = 4'hF;
        addr_i      = 32'h0000_0100;
        wdata_i     = 32'h0;
        hreadyout_i = 1'b1;
        hresp_i     = 1'b0;
        hrdata_i    = 32'h0;

        // Requests are presented during reset and must be ignored.
        repeat (2) begin
            @(negedge core_clk);
            chk("rst_gnt", {63'd0, gnt_o}, 64'd0);
            chk("rst_htrans", {62'd0, htrans_o}, 64'd0);
            chk("rst_hsel", {63'd0, hsel_o}, 64'd0);
            chk("rst_rvalid", {63'd0, rvalid_o}, 64'd0);
            chk("rst_err", {63'd0, err_o}, 64'd0);
        end
        @(posedge core_clk);
        #1;
        core_rst = 1'b0;
        req_i    = 1'b0;
        @(negedge core_clk);
        chk("rst_err_cnt", {48'd0, err_cnt_o}, 64'd0);
        chk("rst_hwdata", {32'd0, hwdata_o}, 64'd0);
        chk("hburst", {61'd0, hburst_o}, 64'd0);
        chk("hmastlock", {63'd0, hmastlock_o}, 64'd0);
        chk("hprot", {60'd0, hprot_o}, 64'd3);

        // Back-to-back zero-wait pipeline over the vector table.
        for (int i = 0; i <= NV; i++) begin
            prev_hr = (i > 0) ? v[(i > 0) ? i - 1 : 0].hrdata : 32'h0;
            if (i < NV) drive(1'b1, v[i].we, v[i].be, v[i].addr, v[i].wdata, 1'b1, 1'b0, prev_hr);
            else        drive(1'b0, 1'b0, 4'h0, 32'h0, 32'h0, 1'b1, 1'b0, prev_hr);
            @(negedge core_clk);
            chk("vec_hready", {63'd0, hready_o}, 64'd1);
            chk("vec_rvalid", {63'd0, rvalid_o}, {63'd0, (i > 0)});
            if (i < NV) begin
                chk("vec_gnt", {63'd0, gnt_o}, 64'd1);
                chk("vec_hsel", {63'd0, hsel_o}, {63'd0, v[i].exp_sel});
                chk("vec_htrans", {62'd0, htrans_o}, v[i].exp_sel ? 64'd2 : 64'd0);
                chk("vec_haddr", {32'd0, haddr_o}, {32'd0, v[i].exp_haddr});
                chk("vec_hsize", {61'd0, hsize_o}, {61'd0, v[i].exp_hsize});
                chk("vec_hwrite", {63'd0, hwrite_o}, {63'd0, v[i].we});
                sb.push_back('{err: v[i].exp_err, rdata: v[i].exp_rdata});
            end else begin
                chk("vec_gnt_idle", {63'd0, gnt_o}, 64'd0);
            end
            if (i > 0 && v[i - 1].we) begin
                chk("vec_hwdata", {32'd0, hwdata_o}, {32'd0, v[i - 1].wdata});
            end
        end
        drive(1'b0, 1'b0, 4'h0, 32'h0, 32'h0, 1'b1, 1'b0, 32'h0);
        @(negedge core_clk);
        chk("vec_sb_drained", sb.size(), 64'd0);
        chk("vec_err_cnt", {48'd0, err_cnt_o}, 64'd2);

        // Two reads, first one stretched by two wait states.
        do_reset();
        drive(1'b1, 1'b0, 4'hF, 32'h0000_0100, 32'h0, 1'b1, 1'b0, 32'h0);
        @(negedge core_clk);
        chk("ws_gnt0", {63'd0, gnt_o}, 64'd1);
        sb.push_back('{err: 1'b0, rdata: 32'h1111_0000});
        repeat (2) begin
            drive(1'b1, 1'b0, 4'hF, 32'h0000_0104, 32'h0, 1'b0, 1'b0, 32'hBBBB_BBBB);
            @(negedge core_clk);
            chk("ws_gnt_held", {63'd0, gnt_o}, 64'd0);
            chk("ws_rvalid_held", {63'd0, rvalid_o}, 64'd0);
            chk("ws_htrans_idle", {62'd0, htrans_o}, 64'd0);
            chk("ws_hready", {63'd0, hready_o}, 64'd0);
        end
        drive(1'b1, 1'b0, 4'hF, 32'h0000_0104, 32'h0, 1'b1, 1'b0, 32'h1111_0000);
        @(negedge core_clk);
        chk("ws_gnt1", {63'd0, gnt_o}, 64'd1);
        chk("ws_rvalid0", {63'd0, rvalid_o}, 64'd1);
        sb.push_back('{err: 1'b0, rdata: 32'h2222_0000});
        drive(1'b0, 1'b0, 4'h0, 32'h0, 32'h0, 1'b1, 1'b0, 32'h2222_0000);
        @(negedge core_clk);
        chk("ws_rvalid1", {63'd0, rvalid_o}, 64'd1);
        drive(1'b0, 1'b0, 4'h0, 32'h0, 32'h0, 1'b1, 1'b0, 32'h0);
        @(negedge core_clk);
        chk("ws_sb_drained", sb.size(), 64'd0);

        // Two-cycle AHB error response, then a request accepted in the second cycle.
        drive(1'b1, 1'b0, 4'hF, 32'h0000_0300, 32'h0, 1'b1, 1'b0, 32'h0);
        @(negedge core_clk);
        chk("ahberr_gnt0", {63'd0, gnt_o}, 64'd1);
        sb.push_back('{err: 1'b1, rdata: 32'h0});
        drive(1'b1, 1'b0, 4'hF, 32'h0000_0304, 32'h0, 1'b0, 1'b1, 32'hEEEE_EEEE);
        @(negedge core_clk);
        chk("ahberr_gnt_first", {63'd0, gnt_o}, 64'd0);
        chk("ahberr_rvalid_first", {63'd0, rvalid_o}, 64'd0);
        drive(1'b1, 1'b0, 4'hF, 32'h0000_0304, 32'h0, 1'b1, 1'b1, 32'hEEEE_EEEE);
        @(negedge core_clk);
        chk("ahberr_rvalid_second", {63'd0, rvalid_o}, 64'd1);
        chk("ahberr_gnt_second", {63'd0, gnt_o}, 64'd1);
        sb.push_back('{err: 1'b0, rdata: 32'h0000_0077});
        drive(1'b0, 1'b0, 4'h0, 32'h0, 32'h0, 1'b1, 1'b0, 32'h0000_0077);
        @(negedge core_clk);
        chk("ahberr_rvalid_next", {63'd0, rvalid_o}, 64'd1);
        chk("ahberr_err_cnt", {48'd0, err_cnt_o}, 64'd1);

        // Out-of-range response completes even when the slave is stalling.
        drive(1'b1, 1'b0, 4'hF, 32'h3000_0000, 32'h0, 1'b1, 1'b0, 32'h0);
        @(negedge core_clk);
        chk("oor_gnt", {63'd0, gnt_o}, 64'd1);
        chk("oor_htrans", {62'd0, htrans_o}, 64'd0);
        chk("oor_hsel", {63'd0, hsel_o}, 64'd0);
        sb.push_back('{err: 1'b1, rdata: 32'h0});
        drive(1'b0, 1'b0, 4'h0, 32'h0, 32'h0, 1'b0, 1'b0, 32'hFFFF_FFFF);
        @(negedge core_clk);
        chk("oor_rvalid", {63'd0, rvalid_o}, 64'd1);
        drive(1'b0, 1'b0, 4'h0, 32'h0, 32'h0, 1'b1, 1'b0, 32'h0);
        @(negedge core_clk);
        chk("oor_err_cnt", {48'd0, err_cnt_o}, 64'd2);
        chk("oor_sb_drained", sb.size(), 64'd0);

        // Reset lands while a read is stalled in its data phase.
        drive(1'b1, 1'b0, 4'hF, 32'h0000_0400, 32'h0, 1'b1, 1'b0, 32'h0);
        @(negedge core_clk);
        chk("midrst_gnt", {63'd0, gnt_o}, 64'd1);
        drive(1'b0, 1'b0, 4'h0, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0);
        @(posedge core_clk);
        #1;
        core_rst = 1'b1;
        @(negedge core_clk);
        chk("midrst_rvalid_in_rst", {63'd0, rvalid_o}, 64'd0);
        drive(1'b0, 1'b0, 4'h0, 32'h0, 32'h0, 1'b1, 1'b0, 32'h9999_9999);
        @(negedge core_clk);
        chk("midrst_rvalid_rst_rdy", {63'd0, rvalid_o}, 64'd0);
        @(posedge core_clk);
        #1;
        core_rst = 1'b0;
        repeat (2) begin
            @(negedge core_clk);
            chk("midrst_rvalid_after", {63'd0, rvalid_o}, 64'd0);
        end
        chk("midrst_err_cnt", {48'd0, err_cnt_o}, 64'd0);
        chk("midrst_sb_empty", sb.size(), 64'd0);

        // Stream out-of-range requests past the counter limit.
        mon_en = 1'b0;
        for (int n = 0; n < 65540; n++) begin
            drive(1'b1, 1'b0, 4'hF, 32'h3000_0000, 32'h0, 1'b1, 1'b0, 32'h0);
        end
        drive(1'b0, 1'b0, 4'h0, 32'h0, 32'h0, 1'b1, 1'b0, 32'h0);
        @(negedge core_clk);
        chk("sat_last_rvalid", {63'd0, rvalid_o}, 64'd1);
        drive(1'b0, 1'b0, 4'h0, 32'h0, 32'h0, 1'b1, 1'b0, 32'h0);
        @(negedge core_clk);
        chk("sat_err_cnt", {48'd0, err_cnt_o}, 64'hFFFF);
        chk("sat_rvalid_idle", {63'd0, rvalid_o}, 64'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
